spi_ram: RTL and testbench



---
 rtl/spi_ram_pkg.sv | 23 ++
 rtl/spi_ram_mem.sv | 68 ++++++
 rtl/spi_ram.sv | 105 ++++++++++
 tb/tb_spi_ram.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI-fronted 256x8 RAM.
// Optional build macro used by this block: SPI_RAM_MEM_CLEAR_EN.
package spi_ram_pkg;

  localparam int MEM_DEPTH_DEF = 256;
  localparam int ADDR_SIZE_DEF = 8;
  localparam int DATA_W        = 8;
  localparam int FRAME_W       = 10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port RAM decoding 10-bit frames {opcode, payload} into address/data operations.
// SPI_RAM_MEM_CLEAR_EN defined: reset also zeroes every word.
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [FRAME_W-1:0] rx_data_i,
  input  logic               rx_valid_i,
  output logic [DATA_W-1:0]  dout_o,
  output logic               tx_valid_o
);

  logic [DATA_W-1:0]    mem_q [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr_q;
  logic [ADDR_SIZE-1:0] rd_addr_q;
  logic [DATA_W-1:0]    dout_q;
  logic                 tx_valid_q;
  logic [1:0]           op;
  logic                 wr_en;

  assign op    = rx_data_i[FRAME_W-1:FRAME_W-2];
  assign wr_en = rx_valid_i && (op == OP_WR_DATA);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      tx_valid_q <= 1'b0;
      if (rx_valid_i) begin
        case (op)
          OP_WR_ADDR: wr_addr_q <= rx_data_i[ADDR_SIZE-1:0];
          OP_RD_ADDR: rd_addr_q <= rx_data_i[ADDR_SIZE-1:0];
          OP_RD_DATA: begin
            dout_q     <= mem_q[rd_addr_q];
            tx_valid_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SPI_RAM_MEM_CLEAR_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr_q] <= rx_data_i[DATA_W-1:0];
    end
  end
`else
  // Contents are deliberately left out of reset so they survive rst.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_addr_q] <= rx_data_i[DATA_W-1:0];
  end
`endif

  assign dout_o     = dout_q;
  assign tx_valid_o = tx_valid_q;

endmodule

// File: rtl/spi_ram.sv
// SPI slave (SS_n/MOSI/MISO, sampled on clk) fronting a 256x8 RAM.
// Build option SPI_RAM_MEM_CLEAR_EN makes reset clear the memory array.
module spi_ram
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  state_e               state_q, state_d;
  logic [3:0]           bit_cnt_q;
  logic [FRAME_W-1:0]   rx_data_q;
  logic                 done_q;
  logic                 rx_valid_q;
  logic                 rd_flag_q;
  logic [DATA_W-1:0]    tx_sh_q;
  logic [3:0]           tx_cnt_q;
  logic                 miso_q;
  logic [DATA_W-1:0]    dout;
  logic                 tx_valid;
  logic                 in_frame;
  logic                 shift_en;

  assign in_frame = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);
  assign shift_en = in_frame && !SS_n && (bit_cnt_q != 4'd10);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!SS_n) state_d = CHK_CMD;
      CHK_CMD: state_d = MOSI ? (rd_flag_q ? READ_DATA : READ_ADD) : WRITE;
      default: ;
    endcase
    if (SS_n) state_d = IDLE;
  end

  // done_q marks the 10th bit; rx_valid follows one edge later so a completed
  // frame still reaches the RAM even if SS_n rises immediately afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rd_flag_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_valid_q <= done_q;
      done_q     <= 1'b0;
      if (SS_n) begin
        bit_cnt_q <= '0;
      end else if (shift_en) begin
        bit_cnt_q <= bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd9) begin
          done_q <= 1'b1;
          if (state_q == READ_ADD)  rd_flag_q <= 1'b1;
          if (state_q == READ_DATA) rd_flag_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) rx_data_q <= {rx_data_q[FRAME_W-2:0], MOSI};
  end

  // Transmit runs on its own; a new tx_valid is ignored until the current byte is out.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt_q <= '0;
      miso_q   <= 1'b0;
    end else if (tx_cnt_q != 4'd0) begin
      miso_q   <= tx_sh_q[DATA_W-1];
      tx_sh_q  <= {tx_sh_q[DATA_W-2:0], 1'b0};
      tx_cnt_q <= tx_cnt_q - 4'd1;
    end else begin
      miso_q <= 1'b0;
      if (tx_valid) begin
        tx_sh_q  <= dout;
        tx_cnt_q <= 4'd8;
      end
    end
  end

  spi_ram_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_data_i  (rx_data_q),
    .rx_valid_i (rx_valid_q),
    .dout_o     (dout),
    .tx_valid_o (tx_valid)
  );

  assign MISO = miso_q;

endmodule

// File: tb/tb_spi_ram.sv
// Directed bench for spi_ram: write/read frames, abort, back-to-back, reset mid-transmit.
module tb_spi_ram;
  import spi_ram_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic SS_n;
  logic MOSI;
  logic MISO;

  int vectors = 0;
  int miscompares = 0;

  spi_ram dut (
    .clk  (clk),
    .rst  (rst),
    .SS_n (SS_n),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after edge E (the edge sampling the 10th bit).
  task automatic send_frame(input logic cmd, input logic [9:0] d);
    SS_n = 1'b0;
    MOSI = cmd;
    tick();
    tick();
    for (int i = 9; i >= 0; i--) begin
      MOSI = d[i];
      tick();
    end
  endtask

  // Samples MISO over E+1..E+12: pre_zero covers E+1..E+3, byte from E+4..E+11, last at E+12.
  task automatic capture_miso(output logic [7:0] b, output logic pre_zero, output logic last);
    pre_zero = 1'b1;
    b = 8'h00;
    last = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k <= 3 && MISO !== 1'b0) pre_zero = 1'b0;
      if (k >= 4 && k <= 11) b[11-k] = MISO;
      if (k == 12) last = MISO;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0;
    tick(); tick();
    rst = 1'b0;
    vectors++;
    if (MISO !== 1'b0) begin
      $display("FAIL reset_miso: got %b expected 0", MISO); miscompares++;
    end
    vectors++;
    if (dut.state_q !== IDLE) begin
      $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE); miscompares++;
    end
    vectors++;
    if (dut.u_mem.wr_addr_q !== 8'd0 || dut.u_mem.rd_addr_q !== 8'd0) begin
      $display("FAIL reset_addr: got wr=%0h rd=%0h expected 0/0",
               dut.u_mem.wr_addr_q, dut.u_mem.rd_addr_q); miscompares++;
    end
    vectors++;
    if (dut.u_mem.dout_q !== 8'd0 || dut.u_mem.tx_valid_q !== 1'b0 || dut.rd_flag_q !== 1'b0) begin
      $display("FAIL reset_ctrl: got dout=%0h txv=%b flag=%b expected 0/0/0",
               dut.u_mem.dout_q, dut.u_mem.tx_valid_q, dut.rd_flag_q); miscompares++;
    end
  endtask

  task automatic test_write_addr;
    logic quiet;
    send_frame(1'b0, 10'b00_00000011);
    SS_n = 1'b1;
    quiet = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (MISO !== 1'b0) quiet = 1'b0;
      if (k == 2) begin
        vectors++;
        if (dut.u_mem.wr_addr_q !== 8'd3) begin
          $display("FAIL wr_addr: got %0d expected 3", dut.u_mem.wr_addr_q); miscompares++;
        end
      end
    end
    vectors++;
    if (quiet !== 1'b1) begin
      $display("FAIL wr_addr_miso: got activity expected 0"); miscompares++;
    end
  endtask

  task automatic test_write_data;
    send_frame(1'b0, 10'b01_00000111);
    SS_n = 1'b1;
    tick();
    vectors++;
    if (dut.rx_valid_q !== 1'b1) begin
      $display("FAIL wr_data_rxv_e1: got %b expected 1", dut.rx_valid_q); miscompares++;
    end
    tick();
    vectors++;
    if (dut.u_mem.mem_q[3] !== 8'd7) begin
      $display("FAIL wr_data_mem3: got %0h expected 7", dut.u_mem.mem_q[3]); miscompares++;
    end
    vectors++;
    if (dut.rx_valid_q !== 1'b0) begin
      $display("FAIL wr_data_rxv_e2: got %b expected 0", dut.rx_valid_q); miscompares++;
    end
    tick();
  endtask

  task automatic test_read_addr;
    logic quiet;
    send_frame(1'b1, 10'b10_00000011);
    vectors++;
    if (dut.rd_flag_q !== 1'b1) begin
      $display("FAIL rd_flag_set: got %b expected 1", dut.rd_flag_q); miscompares++;
    end
    SS_n = 1'b1;
    quiet = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (MISO !== 1'b0) quiet = 1'b0;
    end
    vectors++;
    if (dut.u_mem.rd_addr_q !== 8'd3) begin
      $display("FAIL rd_addr: got %0d expected 3", dut.u_mem.rd_addr_q); miscompares++;
    end
    vectors++;
    if (quiet !== 1'b1) begin
      $display("FAIL rd_addr_miso: got activity expected 0"); miscompares++;
    end
  endtask

  task automatic test_read_data;
    logic [7:0] b;
    logic pre, last;
    send_frame(1'b1, 10'b11_00000011);
    SS_n = 1'b1;
    capture_miso(b, pre, last);
    vectors++;
    if (b !== 8'd7) begin
      $display("FAIL rd_data_byte: got %0h expected 7", b); miscompares++;
    end
    vectors++;
    if (pre !== 1'b1 || last !== 1'b0) begin
      $display("FAIL rd_data_frame: got pre_zero=%b last=%b expected 1/0", pre, last); miscompares++;
    end
    vectors++;
    if (dut.rd_flag_q !== 1'b0) begin
      $display("FAIL rd_flag_clr: got %b expected 0", dut.rd_flag_q); miscompares++;
    end
  endtask

  task automatic test_abort;
    logic [9:0] d;
    logic seen;
    d = 10'b01_00101010;
    SS_n = 1'b0; MOSI = 1'b0;
    tick(); tick();
    for (int i = 9; i >= 5; i--) begin
      MOSI = d[i];
      tick();
    end
    SS_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (dut.rx_valid_q !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      $display("FAIL abort_rxv: got pulse expected none"); miscompares++;
    end
    vectors++;
    if (dut.u_mem.mem_q[3] !== 8'd7) begin
      $display("FAIL abort_mem3: got %0h expected 7", dut.u_mem.mem_q[3]); miscompares++;
    end
    send_frame(1'b0, 10'b00_00000101);
    SS_n = 1'b1;
    tick(); tick(); tick();
    send_frame(1'b0, 10'b01_01011010);
    SS_n = 1'b1;
    tick(); tick();
    vectors++;
    if (dut.u_mem.wr_addr_q !== 8'd5 || dut.u_mem.mem_q[5] !== 8'h5A) begin
      $display("FAIL abort_next: got wr=%0h mem5=%0h expected 5/5a",
               dut.u_mem.wr_addr_q, dut.u_mem.mem_q[5]); miscompares++;
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [7:0] b;
    logic pre, last;
    send_frame(1'b1, 10'b10_00000101);
    SS_n = 1'b1;
    tick();
    send_frame(1'b1, 10'b11_00000000);
    SS_n = 1'b1;
    capture_miso(b, pre, last);
    vectors++;
    if (b !== 8'h5A || pre !== 1'b1 || last !== 1'b0) begin
      $display("FAIL b2b_read: got %0h pre=%b last=%b expected 5a/1/0", b, pre, last); miscompares++;
    end
  endtask

  task automatic test_reset_mid_tx;
    logic [7:0] b;
    logic [7:0] exp_b;
    logic pre, last, quiet;
    send_frame(1'b1, 10'b10_00000011);
    SS_n = 1'b1;
    tick();
    send_frame(1'b1, 10'b11_00000011);
    SS_n = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    vectors++;
    if (dut.tx_cnt_q !== 4'd6) begin
      $display("FAIL midtx_busy: got %0d expected 6", dut.tx_cnt_q); miscompares++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (MISO !== 1'b0 || dut.state_q !== IDLE) begin
      $display("FAIL midtx_rst: got miso=%b state=%0d expected 0/%0d", MISO, dut.state_q, IDLE);
      miscompares++;
    end
    quiet = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (MISO !== 1'b0) quiet = 1'b0;
    end
    vectors++;
    if (quiet !== 1'b1) begin
      $display("FAIL midtx_quiet: got activity expected 0"); miscompares++;
    end
`ifdef SPI_RAM_MEM_CLEAR_EN
    exp_b = 8'd0;
`else
    exp_b = 8'd7;
`endif
    send_frame(1'b1, 10'b10_00000011);
    SS_n = 1'b1;
    tick();
    send_frame(1'b1, 10'b11_00000011);
    SS_n = 1'b1;
    capture_miso(b, pre, last);
    vectors++;
    if (b !== exp_b) begin
      $display("FAIL post_rst_read: got %0h expected %0h", b, exp_b); miscompares++;
    end
  endtask

  initial begin
    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0;
    test_reset();
    test_write_addr();
    test_write_data();
    test_read_addr();
    test_read_data();
    test_abort();
    test_back_to_back();
    test_reset_mid_tx();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
